// File: rtl/dmem_port_arbiter.sv
// Shares the single DataMem port between the MEM stage (P) and a loader/debug master (L).
// Define DMEM_ARB_ROUND_ROBIN_EN for strict round-robin instead of P priority with a starvation limit.
module dmem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_req,
    input  logic              p_wEn,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    input  logic [1:0]        p_size,
    input  logic              p_sign,
    output logic              p_ready,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    output logic              p_err,
    input  logic              l_req,
    input  logic              l_wEn,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    input  logic [1:0]        l_size,
    input  logic              l_sign,
    output logic              l_ready,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              l_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_size,
    output logic              mem_sign,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wEn,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {IDLE, ACCESS} state_e;

    state_e            state_q, state_d;
    logic              wEn_q, wEn_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              sign_q, sign_d;
    logic              id_q, id_d;
    logic              grant, pickL, misaligned;
    logic [DATA_W-1:0] rdataNext;
    logic              p_rvalid_q, l_rvalid_q, p_err_q, l_err_q;
    logic [DATA_W-1:0] p_rdata_q, l_rdata_q;

    assign grant = (state_q == IDLE) & (p_req | l_req);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // Last-winner bit starts at L so P takes the first contested grant.
    logic lastL_q;

    assign pickL = l_req & (~p_req | ~lastL_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        lastL_q <= 1'b1;
        else if (grant) lastL_q <= pickL;
    end
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    logic [3:0] starve_q;

    assign pickL = l_req & (~p_req | (starve_q == STARVE_LIM));

    // Counts P grants that L has had to sit through; any gap in l_req forgives the debt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        starve_q <= 4'd0;
        else if (!l_req)                starve_q <= 4'd0;
        else if (grant && pickL)        starve_q <= 4'd0;
        else if (grant)                 starve_q <= starve_q + 4'd1;
    end
`endif

    assign misaligned = (size_q == 2'b11)
                      | ((size_q == 2'b01) & addr_q[0])
                      | ((size_q == 2'b10) & (addr_q[1:0] != 2'b00));
    assign rdataNext  = (wEn_q | misaligned) ? '0 : mem_rdata;

    always_comb begin
        state_d = state_q;
        p_ready = 1'b0;
        l_ready = 1'b0;
        wEn_d   = wEn_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        sign_d  = sign_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = ACCESS;
                    p_ready = ~pickL;
                    l_ready = pickL;
                    id_d    = pickL;
                    wEn_d   = pickL ? l_wEn   : p_wEn;
                    addr_d  = pickL ? l_addr  : p_addr;
                    wdata_d = pickL ? l_wdata : p_wdata;
                    size_d  = pickL ? l_size  : p_size;
                    sign_d  = pickL ? l_sign  : p_sign;
                end
            end
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wEn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wEn_q   <= wEn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            id_q    <= id_d;
        end
    end

    // Each requester keeps its own response so a later grant to the other side leaves it intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_rvalid_q <= 1'b0;
            l_rvalid_q <= 1'b0;
            p_rdata_q  <= '0;
            l_rdata_q  <= '0;
            p_err_q    <= 1'b0;
            l_err_q    <= 1'b0;
        end else begin
            p_rvalid_q <= (state_q == ACCESS) & ~id_q;
            l_rvalid_q <= (state_q == ACCESS) & id_q;
            if ((state_q == ACCESS) && !id_q) begin
                p_rdata_q <= rdataNext;
                p_err_q   <= misaligned;
            end
            if ((state_q == ACCESS) && id_q) begin
                l_rdata_q <= rdataNext;
                l_err_q   <= misaligned;
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_size  = size_q;
    assign mem_sign  = sign_q;
    assign mem_wdata = wdata_q;
    assign mem_wEn   = wEn_q & ~misaligned & (state_q == ACCESS);

    assign p_rvalid  = p_rvalid_q;
    assign p_rdata   = p_rdata_q;
    assign p_err     = p_err_q;
    assign l_rvalid  = l_rvalid_q;
    assign l_rdata   = l_rdata_q;
    assign l_err     = l_err_q;

endmodule
